dnn_infer_ctrl: RTL and testbench
=================================

# dnn_infer_ctrl

Inference sequencer for the fixed-point sigmoid MNIST engine. It owns the engine's single memory port and arbitrates it between a host pixel stream and the engine. For each image it:

- writes the pixels and the bias word into the activation region;
- pulses the engine start and waits for done, with a timeout;
- takes the argmax of the ten engine outputs and returns it to the host over a valid/ready handshake;
- soft-resets the engine, ready for the next image.

## Interface

Parameters:
- DATA_WIDTH, 16: memory word and engine output width (signed)
- ADDR_WIDTH, 18: memory address width
- ADDR_BASE_A, 0: base address of the activation region
- N_PIX, 400: pixels per image
- N_OUT, 10: engine output count
- BIAS_VAL, 16'h4000: constant 1.0 written after the last pixel
- TIMEOUT, 2^20: maximum cycles in RUN; 0 disables the timeout

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  host pixel valid
- pix_data  in  DATA_WIDTH  host pixel, signed fixed point
- pix_ready  out  1  block accepts a pixel
- res_valid  out  1  result available
- res_ready  in  1  host consumes result
- res_digit  out  4  argmax index; 4'hF on error
- res_err  out  1  timeout occurred for this image
- busy  out  1  high in every state except IDLE
- mem_addr  out  ADDR_WIDTH  shared memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_WIDTH  memory write data
- eng_mem_addr  in  ADDR_WIDTH  engine address request
- eng_start  out  1  engine start pulse
- eng_reset  out  1  engine soft-reset pulse
- eng_done  in  1  engine done
- eng_out  in  N_OUT x DATA_WIDTH  engine outputs, signed

## Operation

States: IDLE, LOAD, BIAS, START, RUN, ARGMAX, RESULT, CLEAR.

- **IDLE**
  - pix_ready=1.
  - An accepted pixel (pix_valid & pix_ready) is written to ADDR_BASE_A+0 and pix_cnt becomes 1.
  - Goes to LOAD, or straight to BIAS if N_PIX=1.
- **LOAD**
  - pix_ready=1.
  - Each accepted pixel is written to ADDR_BASE_A+pix_cnt, then pix_cnt increments.
  - On acceptance of pixel N_PIX-1, goes to BIAS.
  - pix_valid low inserts wait cycles without limit.
- **BIAS**
  - pix_ready=0.
  - Issues a single write of BIAS_VAL to ADDR_BASE_A+N_PIX, then goes to START.
- **START**
  - eng_start=1 for exactly one cycle; goes to RUN.
- **RUN**
  - mem_addr = eng_mem_addr (combinational mux); mem_we=0.
  - to_cnt increments each cycle.
  - eng_done=1 goes to ARGMAX.
  - If TIMEOUT≠0 and to_cnt reaches TIMEOUT-1 with eng_done low: set res_err=1 and res_digit=4'hF, then go to RESULT.
  - eng_done and the timeout in the same cycle: eng_done wins.
- **ARGMAX**
  - One output per cycle for i = 0..N_OUT-1.
  - At i=0 load best=eng_out[0], idx=0.
  - At i>0, if eng_out[i] > best (signed, strict), update best and idx. Ties keep the lowest index.
  - After i=N_OUT-1, res_digit=idx, res_err=0, and go to RESULT.
- **RESULT**
  - res_valid=1; res_digit and res_err are held stable.
  - On res_valid & res_ready, goes to CLEAR.
- **CLEAR**
  - eng_reset=1 for one cycle; goes to IDLE.

Global rules:
- eng_done is ignored outside RUN.
- pix_valid is ignored while pix_ready=0; no data is lost, because the host holds the pixel.
- Outside RUN, mem_addr, mem_we and mem_wdata come from registers. Each write appears on the memory port in the cycle after the pixel is accepted.
- Counters: pix_cnt is $clog2(N_PIX+1) bits, to_cnt is 32 bits, idx is 4 bits. to_cnt clears on entry to RUN.

## Timing

- Reset values:
  - state = IDLE.
  - All counters 0.
  - mem_addr=0, mem_we=0, mem_wdata=0.
  - eng_start=0, eng_reset=0.
  - res_valid=0, res_digit=0, res_err=0, busy=0.
  - pix_ready=1.
- rst asserted mid-image aborts immediately to the reset values. A partially written image is abandoned; the next image starts at address ADDR_BASE_A+0.
- Pixel throughput is one per cycle when pix_valid is held high.
- Last pixel accepted at edge T:
  - its write is visible in cycle T+1;
  - the bias write is visible in T+2;
  - eng_start is high in T+3;
  - RUN begins in T+4.
- eng_done sampled high at edge D: res_valid rises at D+N_OUT+1.
- Result handshake accepted at edge R: eng_reset is high in cycle R+1, and pix_ready=1 from R+2.
- eng_start and eng_reset are never high together and are never longer than one cycle.

## Test plan

- **Nominal:** stream 400 pixels back-to-back, with eng_done after 50 cycles and eng_out[7]=16'h3F00 the maximum.
  - Expect 400 writes to addresses 0..399 and BIAS_VAL at 400.
  - Expect one eng_start pulse, then res_digit=7, res_err=0.
- **Ties and negatives:** all eng_out = -16'sd5, except outputs 3 and 8 = 16'sd100 → res_digit=3.
- **Backpressure:** pix_valid toggled randomly, with res_ready held low for 20 cycles.
  - Addresses stay contiguous with no duplicates.
  - res_valid and res_digit hold stable until the handshake; eng_reset pulses once after it.
- **Timeout:** TIMEOUT=64, eng_done never asserted.
  - res_valid with res_err=1 and res_digit=4'hF exactly 64 cycles after RUN entry.
  - CLEAR follows after res_ready.
- **Reset mid-LOAD:** assert rst after 123 pixels.
  - All outputs return to their reset values.
  - A new 400-pixel image writes from address 0 and completes normally.
- **Arbitration:** in RUN, eng_mem_addr=18'h129be appears on mem_addr the same cycle with mem_we=0. Outside RUN, eng_mem_addr has no effect on mem_addr.

Source files
------------

// File: rtl/dnn_infer_ctrl.sv
// dnn_infer_ctrl: loads an image over the shared memory port, runs the engine with timeout, returns the argmax digit to the host
module dnn_infer_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 18,
  parameter int ADDR_BASE_A = 0,
  parameter int N_PIX = 400,
  parameter int N_OUT = 10,
  parameter logic [DATA_WIDTH-1:0] BIAS_VAL = 16'h4000,
  parameter int TIMEOUT = 1 << 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_valid,
  input  logic [DATA_WIDTH-1:0]            pix_data,
  output logic                             pix_ready,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [3:0]                       res_digit,
  output logic                             res_err,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_we,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [ADDR_WIDTH-1:0]            eng_mem_addr,
  output logic                             eng_start,
  output logic                             eng_reset,
  input  logic                             eng_done,
  input  logic [N_OUT-1:0][DATA_WIDTH-1:0] eng_out
);
  localparam int PW = $clog2(N_PIX + 1);
  typedef enum logic [2:0] {IDLE, LOAD, BIAS, START, RUN, ARGMAX, RESULT, CLEAR} state_t;
  state_t state, state_n;
  logic [PW-1:0] pix_cnt;
  logic [31:0] to_cnt;
  logic [3:0] ai, idx;
  logic signed [DATA_WIDTH-1:0] best, cur;
  logic bias_wr, pix_acc, last_pix, timed_out, better, last_out;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic we_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  assign pix_acc = pix_valid && pix_ready;
  assign last_pix = pix_cnt == PW'(N_PIX - 1);
  assign timed_out = TIMEOUT != 0 && to_cnt == 32'(TIMEOUT - 1);
  assign cur = $signed(eng_out[ai]);
  assign better = ai == 4'd0 || cur > best;
  assign last_out = ai == 4'(N_OUT - 1);
  assign mem_addr = state == RUN ? eng_mem_addr : addr_r;
  assign mem_we = we_r && state != RUN;
  assign mem_wdata = wdata_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    pix_ready = state == IDLE || state == LOAD;
    eng_start = state == START;
    eng_reset = state == CLEAR;
    res_valid = state == RESULT;
    busy = state != IDLE;
    case (state)
      IDLE, LOAD: state_n = pix_acc ? (last_pix ? BIAS : LOAD) : state;
      BIAS: state_n = bias_wr ? START : BIAS;
      START: state_n = RUN;
      RUN: state_n = eng_done ? ARGMAX : (timed_out ? RESULT : RUN);
      ARGMAX: state_n = last_out ? RESULT : ARGMAX;
      RESULT: state_n = res_ready ? CLEAR : RESULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      to_cnt <= '0;
      ai <= '0;
      idx <= '0;
      best <= '0;
      bias_wr <= 1'b0;
      addr_r <= '0;
      we_r <= 1'b0;
      wdata_r <= '0;
      res_digit <= '0;
      res_err <= 1'b0;
    end else begin
      we_r <= 1'b0;
      if (pix_acc) begin
        addr_r <= ADDR_WIDTH'(ADDR_BASE_A) + ADDR_WIDTH'(pix_cnt);
        we_r <= 1'b1;
        wdata_r <= pix_data;
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (state == BIAS && !bias_wr) begin
        addr_r <= ADDR_WIDTH'(ADDR_BASE_A + N_PIX);
        we_r <= 1'b1;
        wdata_r <= BIAS_VAL;
      end
      bias_wr <= state == BIAS;
      to_cnt <= state == RUN ? to_cnt + 32'd1 : '0;
      ai <= state == ARGMAX ? ai + 4'd1 : '0;
      if (state == ARGMAX && better) begin
        best <= cur;
        idx <= ai;
      end
      if (state == ARGMAX && last_out) begin
        res_digit <= better ? ai : idx;
        res_err <= 1'b0;
      end
      if (state == RUN && !eng_done && timed_out) begin
        res_digit <= 4'hF;
        res_err <= 1'b1;
      end
      if (state == CLEAR) pix_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// tb_dnn_infer_ctrl: directed vector table plus hand sequences for load, run, argmax, timeout, handshake and reset
module tb_dnn_infer_ctrl;
  localparam int DW = 16, AW = 18, NP = 400, NO = 10, TO = 64;
  typedef struct {
    logic [NO-1:0][DW-1:0] outs;
    logic [3:0] dig;
    int dly;
    bit bp;
    int hold;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic pix_valid = 1'b0, res_ready = 1'b0, eng_done = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic [AW-1:0] eng_mem_addr = '0;
  logic [NO-1:0][DW-1:0] eng_out = '0;
  logic pix_ready, res_valid, res_err, busy, mem_we, eng_start, eng_reset;
  logic [3:0] res_digit;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  dnn_infer_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit), .res_err(res_err),
    .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .eng_mem_addr(eng_mem_addr), .eng_start(eng_start), .eng_reset(eng_reset),
    .eng_done(eng_done), .eng_out(eng_out)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int wa[$];
  logic [DW-1:0] wd[$];
  int wc[$];
  int n_start = 0, n_reset = 0, pulse_bad = 0;
  logic ps = 1'b0, pr = 1'b0;
  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(int'(mem_addr));
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    n_start <= n_start + int'(eng_start);
    n_reset <= n_reset + int'(eng_reset);
    if ((eng_start && eng_reset) || (eng_start && ps) || (eng_reset && pr)) pulse_bad <= pulse_bad + 1;
    ps <= eng_start;
    pr <= eng_reset;
  end
  int n_chk = 0, n_pass = 0, t_last = 0;
  vec_t tv[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [DW-1:0] pat(input int i, input int s);
    return DW'(i * 3 + s * 97) ^ 16'h5a00;
  endfunction
  task automatic send(input int n, input bit bp, input int seed);
    int i, g;
    bit acc;
    i = 0;
    g = 0;
    while (i < n && g < 20000) begin
      pix_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data = pat(i, seed);
      acc = pix_valid && pix_ready;
      tick();
      g++;
      if (acc) begin
        i++;
        t_last = cyc;
      end
    end
    pix_valid = 1'b0;
    chk("pix_sent", i, n);
  endtask
  task automatic run_image(input vec_t v, input bit to, input int seed);
    int ws, s0, r0, g, s_cyc, d, bad, unst;
    logic [3:0] dig0;
    ws = wa.size();
    s0 = n_start;
    r0 = n_reset;
    d = 0;
    eng_out = v.outs;
    send(NP, v.bp, seed);
    g = 0;
    while (!eng_start && g < 20) begin tick(); g++; end
    chk("start_seen", 32'(eng_start), 1);
    s_cyc = cyc;
    chk("start_lat", s_cyc - t_last, 2);
    tick();
    eng_mem_addr = 18'h129be;
    #1;
    chk("arb_run_addr", 32'(mem_addr), 32'h129be);
    chk("arb_run_we", 32'(mem_we), 0);
    eng_mem_addr = '0;
    if (!to) begin
      while (cyc < s_cyc + 1 + v.dly) tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      d = cyc;
    end
    g = 0;
    while (!res_valid && g < 200) begin tick(); g++; end
    chk("res_valid_seen", 32'(res_valid), 1);
    chk("res_latency", cyc - (to ? s_cyc + 1 : d), to ? TO : NO);
    chk("res_digit", 32'(res_digit), to ? 32'hF : 32'(v.dig));
    chk("res_err", 32'(res_err), 32'(to));
    dig0 = res_digit;
    unst = 0;
    for (int k = 0; k < v.hold; k++) begin
      tick();
      if (!res_valid || res_digit !== dig0 || eng_reset) unst++;
    end
    chk("hold_stable", unst, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("clear_reset", 32'(eng_reset), 1);
    chk("clear_not_ready", 32'(pix_ready), 0);
    eng_mem_addr = 18'h129be;
    #1;
    chk("arb_idle_addr", 32'(mem_addr), NP);
    eng_mem_addr = '0;
    tick();
    chk("idle_ready", {pix_ready, busy, eng_reset, res_valid}, 4'b1000);
    chk("start_pulses", n_start - s0, 1);
    chk("reset_pulses", n_reset - r0, 1);
    chk("wr_count", wa.size() - ws, NP + 1);
    if (wa.size() - ws == NP + 1) begin
      bad = 0;
      for (int k = 0; k < NP; k++) if (wa[ws+k] != k || wd[ws+k] !== pat(k, seed)) bad++;
      if (wa[ws+NP] != NP || wd[ws+NP] !== 16'h4000) bad++;
      chk("wr_contents", bad, 0);
      chk("wr_last_lat", wc[ws+NP-1] - t_last, 0);
      chk("wr_bias_lat", wc[ws+NP] - t_last, 1);
    end
  endtask
  initial begin
    for (int k = 0; k < NO; k++) begin
      tv[0].outs[k] = DW'(k * 256);
      tv[1].outs[k] = 16'hFFFB;
      tv[2].outs[k] = 16'h0000;
      tv[3].outs[k] = 16'h8000;
      tv[4].outs[k] = 16'h0000;
      tv[5].outs[k] = 16'hFFFE;
      tv[6].outs[k] = 16'hFFFF;
    end
    tv[0].outs[7] = 16'h3F00; tv[0].dig = 4'd7; tv[0].dly = 50; tv[0].bp = 0; tv[0].hold = 0;
    tv[1].outs[3] = 16'd100; tv[1].outs[8] = 16'd100; tv[1].dig = 4'd3; tv[1].dly = 3; tv[1].bp = 0; tv[1].hold = 0;
    tv[2].outs[0] = 16'h7FFF; tv[2].dig = 4'd0; tv[2].dly = 20; tv[2].bp = 1; tv[2].hold = 20;
    tv[3].dig = 4'd0; tv[3].dly = 0; tv[3].bp = 0; tv[3].hold = 0;
    tv[4].outs[9] = 16'h0001; tv[4].dig = 4'd9; tv[4].dly = 7; tv[4].bp = 0; tv[4].hold = 0;
    tv[5].outs[5] = 16'hFFFF; tv[5].dig = 4'd5; tv[5].dly = TO - 1; tv[5].bp = 0; tv[5].hold = 0;
    tv[6].outs[2] = 16'h8000; tv[6].outs[6] = 16'h0001; tv[6].dig = 4'd6; tv[6].dly = 10; tv[6].bp = 0; tv[6].hold = 3;
    tick();
    tick();
    rst = 1'b0;
    eng_mem_addr = 18'h129be;
    tick();
    chk("rst_ctrl", {pix_ready, busy, res_valid, res_err, mem_we, eng_start, eng_reset}, 7'b1000000);
    chk("rst_digit", 32'(res_digit), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    eng_mem_addr = '0;
    for (int v = 0; v < 7; v++) run_image(tv[v], 1'b0, v + 1);
    run_image(tv[0], 1'b1, 11);
    send(123, 1'b0, 12);
    rst = 1'b1;
    #2;
    chk("abort_ctrl", {pix_ready, busy, res_valid, res_err, mem_we, eng_start, eng_reset}, 7'b1000000);
    chk("abort_digit", 32'(res_digit), 0);
    chk("abort_addr", 32'(mem_addr), 0);
    chk("abort_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;
    tick();
    run_image(tv[1], 1'b0, 13);
    chk("pulse_shape", pulse_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
